// File: rtl/mc_control_unit_p_if.sv
// rtl/mc_control_unit_p_if.sv - control/datapath bundle for the microcoded sequencer
//
// Purpose: groups every non-clock signal between the sequencer and the
// matrix-multiply datapath.
// Ports (modport master = sequencer, slave = datapath):
//   status, z, dram_rdy, instruction[7:0]        datapath -> sequencer
//   alu_op[2:0], src_sel[3:0], dst_en[NREG+7:0],
//   reg_sel[3:0], byte_sel[BSW-1:0], pc_inc, ac_inc,
//   ar_inc, read_iram, dram_rd, end_process, error sequencer -> datapath
interface mc_control_unit_p_if #(
   parameter int NREG = 8,
   parameter int BSW  = 2
);
   logic            status;
   logic            z;
   logic            dram_rdy;
   logic [7:0]      instruction;
   logic [2:0]      alu_op;
   logic [3:0]      src_sel;
   logic [NREG+7:0] dst_en;
   logic [3:0]      reg_sel;
   logic [BSW-1:0]  byte_sel;
   logic            pc_inc;
   logic            ac_inc;
   logic            ar_inc;
   logic            read_iram;
   logic            dram_rd;
   logic            end_process;
   logic            error;

   modport master (
      input  status, z, dram_rdy, instruction,
      output alu_op, src_sel, dst_en, reg_sel, byte_sel, pc_inc, ac_inc,
             ar_inc, read_iram, dram_rd, end_process, error
   );

   modport slave (
      output status, z, dram_rdy, instruction,
      input  alu_op, src_sel, dst_en, reg_sel, byte_sel, pc_inc, ac_inc,
             ar_inc, read_iram, dram_rd, end_process, error
   );
endinterface

// File: rtl/mc_control_unit_p.sv
// rtl/mc_control_unit_p.sv - parametrised microcoded sequencer for the matrix-multiply core
//
// Purpose: fetches/decodes IRAM instructions and drives bus source select,
// destination write enables, increments and ALU op to the datapath.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mc_control_unit_p_if.master (status/z/dram_rdy/instruction in,
//          all datapath controls plus end_process/error out)
module mc_control_unit_p #(
   parameter int NREG        = 8,
   parameter int IMM_BYTES   = 2,
   parameter int STORE_BYTES = 2,
   parameter int BSW         = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   mc_control_unit_p_if.master bus
);
   typedef enum logic [4:0] {
      S_IDLE, S_FETCH1, S_FETCH2, S_DECODE, S_EXEC,
      S_IMM_LD, S_IMM_TR, S_IMM_RD, S_IMM_AC,
      S_LDM_AR, S_LDM_WAIT, S_LDM_LD,
      S_ST_AR, S_ST_DR, S_ST_WR,
      S_JMP_IR, S_JMP_PC, S_JMP_SKIP, S_HALT
   } state_t;

   localparam logic [BSW-1:0] IMM_LAST = BSW'(IMM_BYTES - 1);
   localparam logic [BSW-1:0] ST_LAST  = BSW'(STORE_BYTES - 1);
   localparam logic [4:0]     NREG_W   = 5'(NREG);

   state_t         state_q, state_d;
   logic [BSW-1:0] cnt_q, cnt_d;
   logic [3:0]     op_q, op_d;
   logic           end_q;
   logic           err_q, err_d;

   logic [3:0]     opcode;
   logic [3:0]     rfield;
   logic           reg_bad;

   logic [2:0]      alu_v;
   logic [3:0]      src_v;
   logic [NREG+7:0] dst_v;
   logic [BSW-1:0]  bsel_v;
   logic            pci_v, aci_v, ari_v, rdi_v, drd_v;

   assign opcode  = bus.instruction[7:4];
   assign rfield  = bus.instruction[3:0];
   assign reg_bad = {1'b0, rfield} >= NREG_W;

   // State register; end_process rises on the clock after HALT is entered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         end_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         err_q   <= err_d;
         if (state_q == S_HALT) end_q <= 1'b1;
      end
   end

   // Next state; opcode is latched in DECODE so EXEC is independent of later IR writes.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE:     if (bus.status) state_d = S_FETCH1;
         S_FETCH1:   state_d = S_FETCH2;
         S_FETCH2:   state_d = S_DECODE;
         S_DECODE: begin
            op_d  = opcode;
            cnt_d = '0;
            case (opcode)
               4'h1: state_d = S_IMM_LD;
               4'h2: state_d = S_LDM_AR;
               4'h3: begin
                  state_d = reg_bad ? S_HALT : S_ST_AR;
                  err_d   = err_q | reg_bad;
               end
               4'h5, 4'h6: begin
                  state_d = reg_bad ? S_HALT : S_EXEC;
                  err_d   = err_q | reg_bad;
               end
               4'hC:    state_d = bus.z ? S_JMP_SKIP : S_JMP_IR;
               4'hD:    state_d = bus.z ? S_JMP_IR : S_JMP_SKIP;
               4'hE:    state_d = S_JMP_IR;
               4'hF:    state_d = S_HALT;
               default: state_d = S_EXEC;
            endcase
         end
         S_EXEC:     state_d = S_FETCH1;
         S_IMM_LD:   state_d = S_IMM_TR;
         S_IMM_TR:   state_d = (cnt_q == IMM_LAST) ? S_IMM_AC : S_IMM_RD;
         S_IMM_RD: begin
            cnt_d   = cnt_q + BSW'(1);
            state_d = S_IMM_LD;
         end
         S_IMM_AC:   state_d = S_FETCH1;
         S_LDM_AR:   state_d = S_LDM_WAIT;
         S_LDM_WAIT: if (bus.dram_rdy) state_d = S_LDM_LD;
         S_LDM_LD:   state_d = S_FETCH1;
         S_ST_AR:    state_d = S_ST_DR;
         S_ST_DR:    state_d = S_ST_WR;
         S_ST_WR: begin
            if (cnt_q == ST_LAST) begin
               state_d = S_FETCH1;
            end else begin
               cnt_d   = cnt_q + BSW'(1);
               state_d = S_ST_DR;
            end
         end
         S_JMP_IR:   state_d = S_JMP_PC;
         S_JMP_PC:   state_d = S_FETCH1;
         S_JMP_SKIP: state_d = S_FETCH1;
         S_HALT:     state_d = S_HALT;
         default:    state_d = S_IDLE;
      endcase
   end

   // Moore output decode of state and byte counter.
   always_comb begin
      alu_v  = '0;
      src_v  = '0;
      dst_v  = '0;
      bsel_v = '0;
      pci_v  = 1'b0;
      aci_v  = 1'b0;
      ari_v  = 1'b0;
      rdi_v  = 1'b0;
      drd_v  = 1'b0;
      case (state_q)
         S_FETCH1: rdi_v = 1'b1;
         S_FETCH2: begin dst_v[2] = 1'b1; pci_v = 1'b1; end
         S_DECODE: rdi_v = 1'b1;
         S_EXEC: begin
            case (op_q)
               4'h4: begin alu_v = 3'd5; dst_v[6] = 1'b1; end
               4'h7: begin alu_v = 3'd1; dst_v[6] = 1'b1; end
               4'h8: begin alu_v = 3'd2; dst_v[6] = 1'b1; end
               4'h9: begin alu_v = 3'd3; dst_v[6] = 1'b1; end
               4'hB: begin alu_v = 3'd4; dst_v[6] = 1'b1; end
               4'hA: aci_v = 1'b1;
               4'h5: begin
                  src_v = 4'd4;
                  for (int r = 0; r < NREG; r++)
                     if (rfield == 4'(r)) dst_v[8+r] = 1'b1;
               end
               4'h6: begin src_v = 4'd6; dst_v[5] = 1'b1; end
               default: ;
            endcase
         end
         S_IMM_LD:   begin dst_v[2] = 1'b1; pci_v = 1'b1; end
         S_IMM_TR:   begin src_v = 4'd1; dst_v[3] = 1'b1; bsel_v = cnt_q; end
         S_IMM_RD:   rdi_v = 1'b1;
         S_IMM_AC:   begin src_v = 4'd2; dst_v[5] = 1'b1; end
         S_LDM_AR:   begin src_v = 4'd4; dst_v[0] = 1'b1; end
         S_LDM_WAIT: drd_v = 1'b1;
         S_LDM_LD:   begin src_v = 4'd5; dst_v[5] = 1'b1; dst_v[4] = 1'b1; end
         S_ST_AR:    begin src_v = 4'd4; dst_v[0] = 1'b1; end
         S_ST_DR:    begin src_v = 4'd7; dst_v[4] = 1'b1; bsel_v = cnt_q; end
         S_ST_WR: begin
            src_v    = 4'd3;
            dst_v[7] = 1'b1;
            ari_v    = (cnt_q != ST_LAST);
         end
         S_JMP_IR:   dst_v[2] = 1'b1;
         S_JMP_PC:   begin src_v = 4'd1; dst_v[1] = 1'b1; end
         S_JMP_SKIP: pci_v = 1'b1;
         default: ;
      endcase
   end

   assign bus.alu_op      = alu_v;
   assign bus.src_sel     = src_v;
   assign bus.dst_en      = dst_v;
   assign bus.reg_sel     = rfield;
   assign bus.byte_sel    = bsel_v;
   assign bus.pc_inc      = pci_v;
   assign bus.ac_inc      = aci_v;
   assign bus.ar_inc      = ari_v;
   assign bus.read_iram   = rdi_v;
   assign bus.dram_rd     = drd_v;
   assign bus.end_process = end_q;
   assign bus.error       = err_q;
endmodule

// File: tb/tb_mc_control_unit_p.sv
// tb/tb_mc_control_unit_p.sv - self-checking bench for mc_control_unit_p
module tb_mc_control_unit_p;
   localparam int NREG        = 8;
   localparam int IMM_BYTES   = 2;
   localparam int STORE_BYTES = 2;
   localparam int BSW         = 2;
   localparam int DW          = NREG + 8;
   localparam int OW          = 3 + 4 + DW + 4 + BSW + 7;

   typedef struct {
      logic           status;
      logic           z;
      logic           rdy;
      logic [7:0]     instr;
      logic [2:0]     alu;
      logic [3:0]     src;
      logic [DW-1:0]  dst;
      logic [BSW-1:0] bsel;
      logic pci, aci, ari, rdi, drd, endp, err;
   } cyc_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   mc_control_unit_p_if #(.NREG(NREG), .BSW(BSW)) bus ();

   mc_control_unit_p #(
      .NREG(NREG), .IMM_BYTES(IMM_BYTES), .STORE_BYTES(STORE_BYTES), .BSW(BSW)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   logic [7:0] iram [256];
   logic [7:0] m_ir;
   logic [7:0] m_pc;
   logic       m_err;
   bit         m_halted;
   int         wait_force = -1;
   int         z_force = -1;
   cyc_t       trace[$];
   int         n_checks = 0;
   int         n_pass = 0;

   int t_pci, t_drd, t_ari, t_dramw, t_trw, t_pcw, t_regw, t_ldm, t_trcode;

   function automatic cyc_t mk();
      cyc_t c;
      c = '{default: '0};
      c.status = 1'($urandom);
      c.z      = 1'($urandom);
      c.rdy    = 1'($urandom);
      c.instr  = m_ir;
      c.err    = m_err;
      return c;
   endfunction

   function automatic logic [OW-1:0] pk(input cyc_t c);
      return {c.alu, c.src, c.dst, c.instr[3:0], c.bsel,
              c.pci, c.aci, c.ari, c.rdi, c.drd, c.endp, c.err};
   endfunction

   function automatic logic [OW-1:0] act();
      return {bus.alu_op, bus.src_sel, bus.dst_en, bus.reg_sel, bus.byte_sel,
              bus.pc_inc, bus.ac_inc, bus.ar_inc, bus.read_iram, bus.dram_rd,
              bus.end_process, bus.error};
   endfunction

   task automatic check(input string name, input logic [OW-1:0] a, input logic [OW-1:0] e);
      n_checks++;
      if (a === e) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, a, e);
   endtask

   task automatic check_int(input string name, input int a, input int e);
      n_checks++;
      if (a == e) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, a, e);
   endtask

   // Instruction-level model: expands one instruction into its cycle list.
   task automatic model_instr();
      cyc_t c;
      logic [3:0] op, r;
      logic zd;
      bit bad, taken;
      c = mk(); c.rdi = 1; trace.push_back(c);
      c = mk(); c.dst[2] = 1; c.pci = 1; trace.push_back(c);
      m_ir = iram[m_pc]; m_pc++;
      c = mk(); c.rdi = 1;
      if (z_force >= 0) c.z = 1'(z_force);
      zd = c.z; trace.push_back(c);
      op  = m_ir[7:4];
      r   = m_ir[3:0];
      bad = (op == 4'h3 || op == 4'h5 || op == 4'h6) && (int'(r) >= NREG);
      if (op == 4'hF || bad) begin
         m_err    = m_err | bad;
         m_halted = 1;
         return;
      end
      case (op)
         4'h1: begin
            for (int k = 0; k < IMM_BYTES; k++) begin
               c = mk(); c.dst[2] = 1; c.pci = 1; trace.push_back(c);
               m_ir = iram[m_pc]; m_pc++;
               c = mk(); c.src = 1; c.dst[3] = 1; c.bsel = BSW'(k); trace.push_back(c);
               if (k < IMM_BYTES - 1) begin c = mk(); c.rdi = 1; trace.push_back(c); end
            end
            c = mk(); c.src = 2; c.dst[5] = 1; trace.push_back(c);
         end
         4'h2: begin
            int w;
            w = (wait_force >= 0) ? wait_force : int'($urandom_range(0, 6));
            c = mk(); c.src = 4; c.dst[0] = 1; trace.push_back(c);
            for (int i = 0; i < w; i++) begin
               c = mk(); c.drd = 1; c.rdy = 0; trace.push_back(c);
            end
            c = mk(); c.drd = 1; c.rdy = 1; trace.push_back(c);
            c = mk(); c.src = 5; c.dst[4] = 1; c.dst[5] = 1; trace.push_back(c);
         end
         4'h3: begin
            c = mk(); c.src = 4; c.dst[0] = 1; trace.push_back(c);
            for (int k = 0; k < STORE_BYTES; k++) begin
               c = mk(); c.src = 7; c.dst[4] = 1; c.bsel = BSW'(k); trace.push_back(c);
               c = mk(); c.src = 3; c.dst[7] = 1; c.ari = (k < STORE_BYTES - 1);
               trace.push_back(c);
            end
         end
         4'hC, 4'hD, 4'hE: begin
            taken = (op == 4'hE) || (op == 4'hC && !zd) || (op == 4'hD && zd);
            if (taken) begin
               c = mk(); c.dst[2] = 1; trace.push_back(c);
               m_ir = iram[m_pc];
               c = mk(); c.src = 1; c.dst[1] = 1; trace.push_back(c);
               m_pc = m_ir;
            end else begin
               c = mk(); c.pci = 1; trace.push_back(c);
               m_pc++;
            end
         end
         default: begin
            c = mk();
            case (op)
               4'h4: begin c.alu = 5; c.dst[6] = 1; end
               4'h7: begin c.alu = 1; c.dst[6] = 1; end
               4'h8: begin c.alu = 2; c.dst[6] = 1; end
               4'h9: begin c.alu = 3; c.dst[6] = 1; end
               4'hB: begin c.alu = 4; c.dst[6] = 1; end
               4'hA: c.aci = 1;
               4'h5: begin c.src = 4; c.dst[8 + int'(r)] = 1; end
               4'h6: begin c.src = 6; c.dst[5] = 1; end
               default: ;
            endcase
            trace.push_back(c);
         end
      endcase
   endtask

   task automatic build_prog(input int n_idle, input int max_instr);
      cyc_t c;
      trace.delete();
      m_pc = 0; m_ir = 0; m_err = 0; m_halted = 0;
      for (int i = 0; i < n_idle; i++) begin c = mk(); c.status = 0; trace.push_back(c); end
      c = mk(); c.status = 1; trace.push_back(c);
      for (int n = 0; n < max_instr && !m_halted; n++) model_instr();
      if (m_halted)
         for (int i = 0; i < 4; i++) begin c = mk(); c.endp = (i > 0); trace.push_back(c); end
   endtask

   task automatic tally();
      int idx;
      t_pci = 0; t_drd = 0; t_ari = 0; t_dramw = 0; t_trw = 0;
      t_pcw = 0; t_regw = 0; t_ldm = 0; t_trcode = 0; idx = 0;
      foreach (trace[i]) begin
         t_pci   += int'(trace[i].pci);
         t_drd   += int'(trace[i].drd);
         t_ari   += int'(trace[i].ari);
         t_dramw += int'(trace[i].dst[7]);
         t_pcw   += int'(trace[i].dst[1]);
         if (trace[i].dst[DW-1:8] != '0) t_regw++;
         if (trace[i].src == 5 && trace[i].dst == DW'(16'h0030)) t_ldm++;
         if (trace[i].dst[3]) begin
            t_trw++;
            t_trcode += int'(trace[i].bsel) << (4 * idx);
            idx++;
         end
      end
   endtask

   task automatic reset_phase();
      cyc_t z0;
      z0 = '{default: '0};
      #1;
      rst_n = 1'b0;
      bus.status = 0; bus.z = 0; bus.dram_rdy = 0; bus.instruction = 8'h00;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("reset_idle", act(), pk(z0));
      end
   endtask

   task automatic run_trace(input int abort_at);
      cyc_t c;
      cyc_t z0;
      for (int i = 0; i < trace.size(); i++) begin
         c = trace[i];
         @(posedge clk);
         #1;
         rst_n           = 1'b1;
         bus.status      = c.status;
         bus.z           = c.z;
         bus.dram_rdy    = c.rdy;
         bus.instruction = c.instr;
         @(negedge clk);
         check($sformatf("cycle%0d", i), act(), pk(c));
         if (i == abort_at) begin
            #1 rst_n = 1'b0;
            #1;
            z0 = '{default: '0};
            z0.instr = c.instr;
            check("async_abort", act(), pk(z0));
            break;
         end
      end
   endtask

   task automatic clear_iram();
      for (int i = 0; i < 256; i++) iram[i] = 8'h00;
   endtask

   initial begin
      // LDAC 0x1234, LDACM with 5-cycle wait, STAC R3, MOVR R9 (illegal)
      clear_iram();
      iram[0] = 8'h10; iram[1] = 8'h34; iram[2] = 8'h12;
      iram[3] = 8'h20; iram[4] = 8'h33; iram[5] = 8'h59;
      wait_force = 5;
      build_prog(0, 10);
      tally();
      check_int("d1_len", trace.size(), 36);
      check_int("d1_pc_inc", t_pci, 6);
      check_int("d1_dram_rd", t_drd, 6);
      check_int("d1_ldm_ld", t_ldm, 1);
      check_int("d1_ar_inc", t_ari, 1);
      check_int("d1_dram_wr", t_dramw, 2);
      check_int("d1_tr_writes", t_trw, 2);
      check_int("d1_tr_bsel", t_trcode, 16'h0010);
      check_int("d1_reg_writes", t_regw, 0);
      check_int("d1_halt0_end", int'(trace[trace.size()-4].endp), 0);
      check_int("d1_final_err", int'(trace[trace.size()-1].err), 1);
      check_int("d1_final_end", int'(trace[trace.size()-1].endp), 1);
      reset_phase();
      run_trace(-1);
      wait_force = -1;

      // JMP to 4, then END
      clear_iram();
      iram[0] = 8'hE0; iram[1] = 8'h04; iram[4] = 8'hF0;
      build_prog(1, 10);
      tally();
      check_int("d2_len", trace.size(), 14);
      check_int("d2_pc_inc", t_pci, 2);
      check_int("d2_pc_writes", t_pcw, 1);
      check_int("d2_final_err", int'(trace[trace.size()-1].err), 0);
      check_int("d2_final_end", int'(trace[trace.size()-1].endp), 1);
      reset_phase();
      run_trace(-1);

      // JPNZ / JPZ with z forced each way
      clear_iram();
      iram[0] = 8'hC0; iram[1] = 8'h08; iram[2] = 8'hD0; iram[3] = 8'h06;
      iram[6] = 8'hF0; iram[8] = 8'hD0; iram[10] = 8'hF0;
      for (int zf = 0; zf < 2; zf++) begin
         z_force = zf;
         build_prog(0, 10);
         tally();
         check_int($sformatf("d3_z%0d_pc_inc", zf), t_pci, 4);
         check_int($sformatf("d3_z%0d_pc_writes", zf), t_pcw, 1);
         reset_phase();
         run_trace(-1);
      end
      z_force = -1;

      // Reset while waiting on DRAM
      clear_iram();
      iram[0] = 8'h20;
      wait_force = 10;
      build_prog(0, 1);
      check_int("d4_wait_cycle", int'(trace[7].drd), 1);
      reset_phase();
      run_trace(7);
      wait_force = -1;

      // Random programs
      for (int p = 0; p < 40; p++) begin
         for (int i = 0; i < 256; i++) begin
            logic [3:0] op, r;
            op = ($urandom_range(0, 29) == 0) ? 4'hF : 4'($urandom_range(0, 14));
            r  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
            iram[i] = {op, r};
         end
         build_prog(int'($urandom_range(0, 2)), 40);
         reset_phase();
         run_trace(-1);
      end

      reset_phase();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/mc_control_unit_p.md
Name: mc_control_unit_p

Overview:
- Parametrised microcoded sequencer for the matrix-multiply processor core. Next generation of the single-core control unit.
- Fetches and decodes IRAM instructions and drives bus-source select, destination write enables, increments and ALU op to the datapath.
- Adds over the previous generation:
  - register-indexed MOVR/MVAC/STAC;
  - multi-byte immediates and stores;
  - DRAM-ready handshake;
  - JPZ and JMP;
  - illegal-register trap.

Parameters:
- NREG, 8: general registers R0..R(NREG-1); 1..16.
- IMM_BYTES, 2: immediate bytes following LDAC; 1..4.
- STORE_BYTES, 2: bytes written by STAC; 1..4.
- BSW, 2: byte_sel width, at least clog2(max(IMM_BYTES,STORE_BYTES)), minimum 1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- status  in  1  level; 1 = run.
- z  in  1  ALU zero flag.
- instruction  in  8  IR contents; opcode [7:4], reg field [3:0].
- dram_rdy  in  1  DRAM read data valid.
- alu_op  out  3  0 none, 1 add, 2 sub, 3 mul, 4 dec, 5 clear.
- src_sel  out  4  bus source: 0 none, 1 IR, 2 TR, 3 DR, 4 AC, 5 DRAM, 6 R[reg_sel], 7 byte byte_sel of R[reg_sel].
- dst_en  out  NREG+8  one-hot write enables: [0] AR, [1] PC, [2] IR, [3] TR byte byte_sel, [4] DR, [5] AC from bus, [6] AC from ALU, [7] DRAM, [8+r] Rr.
- reg_sel  out  4  instruction[3:0].
- byte_sel  out  BSW  byte index for TR/REG_BYTE.
- pc_inc  out  1  PC <- PC+1.
- ac_inc  out  1  AC <- AC+1.
- ar_inc  out  1  AR <- AR+1.
- read_iram  out  1  IRAM read strobe.
- dram_rd  out  1  DRAM read request.
- end_process  out  1  registered halt flag.
- error  out  1  sticky illegal-register flag.

Behaviour:
- Reset: rst_n=0 asynchronously forces state IDLE, byte counter 0, end_process=0, error=0. Reset mid-operation (including mid-DRAM-wait) aborts immediately with no partial-op completion.
- Outputs: combinational Moore decode of state and byte counter, except end_process and error. Default for all outputs is 0.
- Opcodes: 0 NOP, 1 LDAC, 2 LDACM, 3 STAC, 4 CLAC, 5 MOVR, 6 MVAC, 7 ADD, 8 SUB, 9 MUL, A INC, B DEC, C JPNZ, D JPZ, E JMP, F END.
- IDLE: all outputs 0; go to FETCH1 when status=1.
- Fetch:
  - FETCH1: read_iram=1.
  - FETCH2: dst IR, pc_inc=1.
  - DECODE: read_iram=1 (operand prefetch); branch on opcode. Decode uses instruction as sampled in this state.
- Single-cycle ops go DECODE -> EXEC -> FETCH1, so 4 cycles total:
  - NOP: no outputs.
  - CLAC / ADD / SUB / MUL / DEC: alu_op 5/1/2/3/4, dst AC-ALU.
  - INC: ac_inc=1.
  - MOVR: src AC, dst R[reg].
  - MVAC: src R[reg], dst AC-bus.
- LDAC, for k = 0..IMM_BYTES-1 (LSB first):
  - IMM_LD: dst IR, pc_inc.
  - IMM_TR: src IR, dst TR, byte_sel=k.
  - IMM_RD: read_iram=1, only when k is not last.
  - Then IMM_AC: src TR, dst AC-bus -> FETCH1.
- LDACM:
  - LDM_AR: src AC, dst AR.
  - LDM_WAIT: dram_rd=1; stays in this state while dram_rdy=0, with no timeout.
  - LDM_LD: entered when dram_rdy=1; src DRAM, dst AC-bus and DR -> FETCH1.
  - dram_rdy is ignored outside LDM_WAIT.
- STAC stores DRAM[AC+k] <- byte k of R[reg]:
  - ST_AR: src AC, dst AR.
  - Per k: ST_DR (src 7, byte_sel=k, dst DR), then ST_WR (src DR, dst DRAM, ar_inc=1 unless k is last).
  - Last byte -> FETCH1.
- Jumps, resolved in DECODE:
  - Taken condition: JPNZ when z=0, JPZ when z=1, JMP always.
  - Taken path: JMP_IR (dst IR) -> JMP_PC (src IR, dst PC) -> FETCH1.
  - Not-taken path: JMP_SKIP (pc_inc) -> FETCH1.
- Illegal register: MOVR, MVAC or STAC with reg >= NREG goes DECODE -> HALT and sets error=1. No register or DRAM write occurs.
- END opcode: DECODE -> HALT.
- HALT: all outputs 0; state is terminal until reset. end_process=1 from the clock after HALT is entered, and is sticky.
- status is sampled only in IDLE; deassertion mid-program has no effect.
- Byte counter: BSW bits; cleared on entry to each multi-byte sequence; never wraps past the last index.
- dst_en is at most one-hot per cycle, except LDM_LD, which sets both AC-bus and DR.

Test Plan:
- Reset/idle: rst_n low for 3 cycles with status=0 -> all outputs 0. Assert status -> FETCH1 next cycle with read_iram=1. Assert rst_n low mid-LDM_WAIT -> IDLE in the same cycle.
- LDAC with IMM_BYTES=2, program 0x10,0x34,0x12 -> TR written with byte_sel=0 then 1. IMM_AC asserts src=2, dst[5]. pc_inc pulses 3 times total.
- LDACM with dram_rdy held low 5 cycles -> dram_rd high for 6 cycles. LDM_LD occurs the cycle after dram_rdy rises, with src=5 and dst bits 4 and 5 set.
- STAC R3 with STORE_BYTES=2 -> byte_sel 0 then 1, two dst[7] pulses, ar_inc exactly once.
- Jumps: JPNZ with z=0 -> dst[1] with src=1. JPNZ with z=1 -> pc_inc only. JPZ inverse behaviour. JMP always taken.
- Halt paths: MOVR with reg=9 at NREG=8 -> no dst[8+r] write, error=1, end_process=1 one cycle after HALT. Opcode F -> end_process=1 with error=0.
